// File: rtl/ps2_key_decoder.sv
// Set-2 scan-byte assembler: folds E0/F0/E1 prefixes into one key event per
// keystroke and keeps a held-key bitmap of the arcade controls.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TO_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] code,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] key_state,
    output logic       seq_err
);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    state_t          state, cur, nstate;
    logic [TO_W-1:0] to_cnt;
    logic [2:0]      pause_cnt, npause;
    logic            to_hit, emit, e_ext, e_brk;
    logic [7:0]      mask;

    function automatic logic [7:0] key_mask(input logic [7:0] c, input logic ext);
        logic [7:0] m;
        m = '0;
        case ({ext, c})
            9'h175:  m = 8'h01;
            9'h172:  m = 8'h02;
            9'h16B:  m = 8'h04;
            9'h174:  m = 8'h08;
            9'h029:  m = 8'h10;
            9'h05A:  m = 8'h20;
            9'h016:  m = 8'h40;
            9'h076:  m = 8'h80;
            default: m = '0;
        endcase
        return m;
    endfunction

    // A byte arriving on the timeout cycle is decoded as if the sequence had
    // already been abandoned, so the decode below runs from `cur`, not `state`.
    always_comb begin
        to_hit = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
        cur    = to_hit ? IDLE : state;
        nstate = cur;
        npause = to_hit ? 3'd0 : pause_cnt;
        emit   = 1'b0;
        e_ext  = 1'b0;
        e_brk  = 1'b0;
        if (valid) begin
            case (cur)
                IDLE: begin
                    case (code)
                        8'hE0: nstate = EXT;
                        8'hF0: nstate = BRK;
                        8'hE1: begin
                            nstate = PAUSE;
                            npause = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: nstate = IDLE;
                        default: emit = 1'b1;
                    endcase
                end
                EXT: begin
                    case (code)
                        8'hF0:        nstate = EXT_BRK;
                        8'h12, 8'h59: nstate = IDLE;
                        8'hE0:        nstate = EXT;
                        default: begin
                            emit   = 1'b1;
                            e_ext  = 1'b1;
                            nstate = IDLE;
                        end
                    endcase
                end
                BRK: begin
                    case (code)
                        8'hF0: nstate = BRK;
                        8'hE0: nstate = EXT_BRK;
                        default: begin
                            emit   = 1'b1;
                            e_brk  = 1'b1;
                            nstate = IDLE;
                        end
                    endcase
                end
                EXT_BRK: begin
                    nstate = IDLE;
                    if (code != 8'h12 && code != 8'h59) begin
                        emit  = 1'b1;
                        e_ext = 1'b1;
                        e_brk = 1'b1;
                    end
                end
                PAUSE: begin
                    if (pause_cnt <= 3'd1) begin
                        npause = 3'd0;
                        nstate = IDLE;
                    end else begin
                        npause = pause_cnt - 3'd1;
                    end
                end
                default: nstate = IDLE;
            endcase
        end
        mask = key_mask(code, e_ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            to_cnt    <= '0;
            pause_cnt <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_ext   <= 1'b0;
            evt_break <= 1'b0;
            key_state <= '0;
            seq_err   <= 1'b0;
        end else begin
            state     <= nstate;
            pause_cnt <= npause;
            evt_valid <= emit;
            seq_err   <= to_hit && !valid;
            if (valid || to_hit || state == IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (emit) begin
                evt_code  <= code;
                evt_ext   <= e_ext;
                evt_break <= e_brk;
                key_state <= e_brk ? (key_state & ~mask) : (key_state | mask);
            end
        end
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Consumes the byte stream from the PS2 receiver (`valid` pulse plus 8-bit `code`) and assembles Set-2 make/break sequences (E0 extended prefix, F0 break prefix, E1 Pause sequence) into one key event per keystroke.
- Maintains a held-key bitmap of the arcade controls, read directly by game logic.
- Sits between the PS2 receiver and the game controller/input logic.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles allowed between bytes of a multi-byte sequence before the partial sequence is abandoned (1 ms at 50 MHz).
- TO_W, 16: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- valid  input  1  one-cycle pulse, `code` holds a received byte.
- code  input  8  received scan byte, sampled only when `valid`=1.
- evt_valid  output  1  one-cycle pulse, a complete key event is presented.
- evt_code  output  8  final scan byte of the event.
- evt_ext  output  1  event was E0-prefixed.
- evt_break  output  1  1=release, 0=press.
- key_state  output  8  held keys: [0] up E0 75, [1] down E0 72, [2] left E0 6B, [3] right E0 74, [4] fire 29, [5] start 5A (non-ext), [6] coin 16, [7] esc 76.
- seq_err  output  1  one-cycle pulse on timeout abandonment.

Behaviour:
- Clocking and reset:
  - Clock is `clk`. Reset is synchronous and active-high on `rst`.
  - Reset (synchronous, `rst`=1 at a clk edge): state=IDLE; evt_valid=0, evt_code=00, evt_ext=0, evt_break=0, key_state=00, seq_err=0; timeout counter=0; pause counter=0.
  - Reset mid-sequence discards the partial sequence. A `valid` in the same cycle as `rst` is ignored.
- States: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions happen only on cycles with `valid`=1, except timeout.
- From IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, pause counter=7.
  - AA, FA, FE, EE, 00, FF are controller responses: ignored, stay IDLE.
  - Any other byte: emit press (ext=0, break=0), stay IDLE.
- From EXT:
  - F0 -> EXT_BRK.
  - 12 or 59 (fake-shift) -> IDLE, no event.
  - E0 -> stay EXT.
  - Other byte: emit press (ext=1) -> IDLE.
- From BRK:
  - F0 or E0 -> stay in the current prefix state (BRK; E0 upgrades to EXT_BRK).
  - Other byte: emit release (ext=0) -> IDLE.
- From EXT_BRK:
  - 12 or 59 -> IDLE, no event.
  - Other byte: emit release (ext=1) -> IDLE.
- PAUSE:
  - Each `valid` decrements the pause counter. No event is emitted.
  - When the counter reaches 0 -> IDLE.
  - Total 8 bytes consumed, E1 included.
- Emit:
  - evt_valid=1 exactly one cycle after the `valid` cycle of the final byte (1-cycle latency).
  - evt_code, evt_ext, evt_break are registered in the same cycle and hold until the next event.
- key_state:
  - Updated in the same cycle evt_valid asserts: the matching bit is set on press and cleared on break.
  - Both code and ext must match; e.g. non-ext 75 (keypad 8) does not touch bit0.
  - Unmapped codes change nothing.
  - Typematic repeat presses re-set an already-set bit; evt_valid still pulses per repeat.
- Timeout:
  - The counter increments every cycle while state != IDLE and clears on each `valid`.
  - On reaching TIMEOUT_CYCLES: state -> IDLE, pause counter=0, seq_err pulses 1 cycle, no event, key_state unchanged.
  - A `valid` in the same cycle as timeout is processed from IDLE; timeout is not flagged.
- Back-to-back `valid` on consecutive cycles must be handled, one byte per cycle.
- No other outputs pulse. seq_err and evt_valid are never both high.

Test Plan:
- Bytes E0, 75 -> one evt_valid pulse, evt_code=75, ext=1, break=0, key_state=01; then E0, F0, 75 -> evt_code=75, ext=1, break=1, key_state=00.
- Bytes 75, F0, 75 (non-ext) -> two events: press then release with evt_code=75, ext=0; key_state stays 00 throughout.
- Byte 29 repeated 3 times, then F0 29 -> 3 press pulses, key_state[4]=1 throughout, then a release with key_state=00; fake-shift E0 12 -> no event.
- Bytes E1 14 77 E1 F0 14 F0 77, then 5A -> no events for the first 8 bytes; one press 5A, key_state=20.
- E0, then idle TIMEOUT_CYCLES cycles, then 75 -> seq_err pulse at the timeout cycle; 75 is decoded as a non-ext press, key_state=00.
- E0 F0, assert `rst` for 1 cycle, then 6B -> all outputs 0 after reset; 6B decoded as a non-ext press (no key_state change); E0 6B afterwards sets key_state=04.
